sgd_server_recv: RTL and testbench
==================================

# sgd_server_recv

Receive-side aggregation stage of the SGD parameter server. It takes one TCP RX packet per worker per round, matches each packet's session to a worker slot, and sums the per-bank signed 32-bit partial dot products across all workers. When every worker has contributed, it presents the per-bank totals for one cycle, in the exact array form the server transmit stage (`sgd_server_send`) consumes.

## Interface
Parameters:
- `NUM_OF_BANKS`, default 8: banks per beat. Bank n occupies data bits [32n+31:32n]. NUM_OF_BANKS*32 ≤ 512.
- `WORKER_NUM`, default 4: workers per round (1..16).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `session_id`  in  [WORKER_NUM-1:0][15:0]  TCP session of each worker slot. Static during operation.
- `m_axis_rx_metadata`  axis_meta.slave  valid/ready/data; data[15:0] is the RX session.
- `m_axis_rx_data`  axi_stream.slave  valid/ready/data[511:0]/keep[63:0]/last.
- `ax_minus_b_sign_shifted_result`  out  signed [31:0] [NUM_OF_BANKS-1:0]  per-bank round totals.
- `ax_minus_b_sign_shifted_result_valid`  out  [NUM_OF_BANKS-1:0]  one-cycle pulse; all bits are identical.
- `drop_cnt`  out  32  packets discarded (unknown or duplicate session). Wraps.
- `round_cnt`  out  32  completed rounds. Wraps.

## Operation
- FSM states: IDLE, LOOKUP, RECV_FIRST, RECV_DRAIN.
- IDLE:
  - meta ready=1, data ready=0.
  - On meta handshake, latch the session and go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the latched session against all `session_id` entries; the lowest-index match wins.
  - The packet is *accepted* if a match exists and that worker's bit in the `seen` bitmap is 0.
  - Otherwise it is *dropped*, and `drop_cnt` increments at the LOOKUP→RECV_FIRST edge.
  - Next state is always RECV_FIRST.
- RECV_FIRST:
  - data ready=1.
  - On beat handshake, if accepted: acc[n] += beat bank n for every bank, and set seen[w].
  - If the beat has `last`=1, go to IDLE; else go to RECV_DRAIN. `keep` is ignored.
- RECV_DRAIN:
  - data ready=1.
  - Extra beats are consumed and discarded.
  - The `last` handshake returns the FSM to IDLE.
- Round completion: when the accepted beat makes `seen` all-ones, the same clock edge:
  - loads acc[n]+beat[n] into the output registers and asserts valid;
  - clears all acc to 0 and `seen` to 0;
  - increments `round_cnt`.
- Arithmetic: 32-bit two's complement, wrap-around on overflow (default build).
- Packets for the next round may arrive immediately; there is no back-pressure from downstream. The consumer must accept a pulse every cycle it is asserted.

## Timing
- Reset values:
  - outputs 0, valid 0, both ready 0 during reset;
  - FSM in IDLE, acc 0, `seen` 0, both counters 0.
  - Meta ready rises on the first cycle after reset deasserts.
- Minimum packet cost is 3 cycles: meta at T, LOOKUP at T+1, first beat accepted at T+2 at the earliest.
- Result latency: the completing beat is accepted at cycle D; outputs and valid are visible at D+1; valid is high for exactly one cycle.
- Outputs hold their value until the next completion.
- Data valid asserted while in IDLE/LOOKUP is not accepted: ready is 0.
- Meta valid asserted while not in IDLE is not accepted.
- Reset asserted mid-round or mid-packet immediately discards the partial round. Counters are cleared.

## Configuration
- `SGD_SERVER_RECV_SATURATE_EN`:
  - Defined: accumulation saturates at +2^31-1 / −2^31. Once saturated, the value stays clamped unless a later addend moves it back in range. The check is on each addition.
  - Undefined: plain wrap-around addition.

## Test plan
- WORKER_NUM=4, sessions {10,11,12,13}. Send one single-beat packet each with bank0 = 1, 2, 3, 4 → bank0 result 10 with one valid pulse one cycle after the 4th beat; `round_cnt`=1.
- Session 99 packet → consumed with data ready high, `drop_cnt`=1, no accumulation; a following full round still totals correctly.
- Session 11 sent twice within a round with bank0 = 5 then 7 → second copy dropped (`drop_cnt`=1); round total uses 5.
- Three-beat packet with the first beat bank0=−3 and other beats all 0x7FFFFFFF → only −3 contributes; FSM returns to IDLE after the `last` beat.
- Two workers, bank0 = 0x7FFFFFFF and 1 → result 0x80000000 without the macro; 0x7FFFFFFF with `SGD_SERVER_RECV_SATURATE_EN`.
- Assert `rst` after 2 of 4 packets, release, then send 4 packets of value 1 → result 4, not 4 plus the stale partial sum.

Source files
------------

// File: rtl/sgd_server_recv.sv
// ============================================================================
// Module      : sgd_server_recv
// Description : Receive-side aggregation for the SGD parameter server. Maps
//               each RX packet's session to a worker slot, sums the per-bank
//               signed 32-bit partial results of one beat per worker, and
//               emits the per-bank round totals as a one-cycle pulse.
// Options     : SGD_SERVER_RECV_SATURATE_EN - saturating accumulation
//               (default build wraps on overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgd_server_recv #(
  parameter int NUM_OF_BANKS = 8,
  parameter int WORKER_NUM   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORKER_NUM-1:0][15:0]   session_id,
  // RX metadata stream (data[15:0] = session)
  input  logic                          m_axis_rx_metadata_valid,
  output logic                          m_axis_rx_metadata_ready,
  input  logic [15:0]                   m_axis_rx_metadata_data,
  // RX payload stream
  input  logic                          m_axis_rx_data_valid,
  output logic                          m_axis_rx_data_ready,
  input  logic [511:0]                  m_axis_rx_data_data,
  input  logic [63:0]                   m_axis_rx_data_keep,
  input  logic                          m_axis_rx_data_last,
  // Round totals towards the transmit stage
  output logic signed [31:0]            ax_minus_b_sign_shifted_result [NUM_OF_BANKS],
  output logic [NUM_OF_BANKS-1:0]       ax_minus_b_sign_shifted_result_valid,
  output logic [31:0]                   drop_cnt,
  output logic [31:0]                   round_cnt
);

  localparam int c_WIDX_W = (WORKER_NUM > 1) ? $clog2(WORKER_NUM) : 1;
  localparam int c_DATA_W = NUM_OF_BANKS * 32;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOOKUP     = 2'd1,
    S_RECV_FIRST = 2'd2,
    S_RECV_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_meta_hs;
  logic                   w_beat_hs;
  logic                   r_meta_ready;
  logic                   r_data_ready;
  logic [15:0]            r_session;
  logic                   r_accept;
  logic [c_WIDX_W-1:0]    r_widx;
  logic                   w_hit;
  logic [c_WIDX_W-1:0]    w_hit_idx;
  logic                   w_accept;
  logic [WORKER_NUM-1:0]  r_seen;
  logic [WORKER_NUM-1:0]  w_seen_nxt;
  logic                   w_first_acc;
  logic                   w_complete;
  logic                   r_valid;
  logic [31:0]            r_drop_cnt;
  logic [31:0]            r_round_cnt;
  logic [31:0]            r_acc    [NUM_OF_BANKS];
  logic [31:0]            r_result [NUM_OF_BANKS];
  logic [31:0]            w_beat   [NUM_OF_BANKS];
  logic [31:0]            w_sum    [NUM_OF_BANKS];
  logic                   w_unused_hi;
  logic                   w_unused_ok;

  // One bank addition: wrap-around by default, clamped when saturation is built in.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
`ifdef SGD_SERVER_RECV_SATURATE_EN
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      acc_add = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      acc_add = s[31:0];
`else
    acc_add = a + b;
`endif
  endfunction

  // Slice the beat into banks and form the candidate sums.
  for (genvar n = 0; n < NUM_OF_BANKS; n++) begin : g_bank
    assign w_beat[n] = m_axis_rx_data_data[32*n +: 32];
    assign w_sum[n]  = acc_add(r_acc[n], w_beat[n]);
  end

  // Payload bits above the used banks (and keep) carry nothing for this stage.
  if (c_DATA_W < 512) begin : g_unused_hi
    assign w_unused_hi = ^m_axis_rx_data_data[511:c_DATA_W];
  end else begin : g_no_unused_hi
    assign w_unused_hi = 1'b0;
  end
  assign w_unused_ok = w_unused_hi ^ (^m_axis_rx_data_keep);

  // Session lookup; scanning downwards leaves the lowest matching index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int w = WORKER_NUM - 1; w >= 0; w--) begin
      if (session_id[w] == r_session) begin
        w_hit     = 1'b1;
        w_hit_idx = c_WIDX_W'(w);
      end
    end
    w_accept = w_hit && !r_seen[w_hit_idx];
  end

  // Next-state logic and stream handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_meta_hs   = 1'b0;
    w_beat_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_meta_hs = m_axis_rx_metadata_valid && r_meta_ready;
        if (w_meta_hs) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_state_nxt = S_RECV_FIRST;
      end
      S_RECV_FIRST: begin
        w_beat_hs = m_axis_rx_data_valid && r_data_ready;
        if (w_beat_hs) w_state_nxt = m_axis_rx_data_last ? S_IDLE : S_RECV_DRAIN;
      end
      S_RECV_DRAIN: begin
        w_beat_hs = m_axis_rx_data_valid && r_data_ready;
        if (w_beat_hs && m_axis_rx_data_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_first_acc = (r_state == S_RECV_FIRST) && w_beat_hs && r_accept;
  assign w_seen_nxt  = r_seen | (WORKER_NUM'(1) << r_widx);
  assign w_complete  = w_first_acc && (&w_seen_nxt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Registered readies so both stay low through reset and rise only afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta_ready <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_meta_ready <= (w_state_nxt == S_IDLE);
      r_data_ready <= (w_state_nxt == S_RECV_FIRST) || (w_state_nxt == S_RECV_DRAIN);
    end
  end

  // Latch the session, resolve the worker slot and count drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_session  <= '0;
      r_accept   <= 1'b0;
      r_widx     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_meta_hs) r_session <= m_axis_rx_metadata_data;
      if (r_state == S_LOOKUP) begin
        r_accept <= w_accept;
        r_widx   <= w_hit_idx;
        if (!w_accept) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  // Accumulate accepted first beats; publish and clear on round completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_OF_BANKS; n++) begin
        r_acc[n]    <= '0;
        r_result[n] <= '0;
      end
      r_seen      <= '0;
      r_valid     <= 1'b0;
      r_round_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_complete) begin
        for (int n = 0; n < NUM_OF_BANKS; n++) begin
          r_result[n] <= w_sum[n];
          r_acc[n]    <= '0;
        end
        r_seen      <= '0;
        r_valid     <= 1'b1;
        r_round_cnt <= r_round_cnt + 32'd1;
      end else if (w_first_acc) begin
        for (int n = 0; n < NUM_OF_BANKS; n++) r_acc[n] <= w_sum[n];
        r_seen <= w_seen_nxt;
      end
    end
  end

  assign m_axis_rx_metadata_ready = r_meta_ready;
  assign m_axis_rx_data_ready     = r_data_ready;
  assign ax_minus_b_sign_shifted_result_valid = {NUM_OF_BANKS{r_valid}};
  assign drop_cnt  = r_drop_cnt;
  assign round_cnt = r_round_cnt;

  for (genvar n = 0; n < NUM_OF_BANKS; n++) begin : g_out
    assign ax_minus_b_sign_shifted_result[n] = r_result[n];
  end

endmodule

`default_nettype wire

// File: tb/tb_sgd_server_recv.sv
// ============================================================================
// Module      : tb_sgd_server_recv
// Description : Directed self-checking bench for sgd_server_recv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgd_server_recv;

  localparam int NB = 8;
  localparam int NW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NW-1:0][15:0]   session_id;
  logic                  meta_valid;
  logic                  meta_ready;
  logic [15:0]           meta_data;
  logic                  data_valid;
  logic                  data_ready;
  logic [511:0]          data_data;
  logic [63:0]           data_keep;
  logic                  data_last;
  logic signed [31:0]    result [NB];
  logic [NB-1:0]         result_valid;
  logic [31:0]           drop_cnt;
  logic [31:0]           round_cnt;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  sgd_server_recv #(.NUM_OF_BANKS(NB), .WORKER_NUM(NW)) dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .session_id                           (session_id),
    .m_axis_rx_metadata_valid             (meta_valid),
    .m_axis_rx_metadata_ready             (meta_ready),
    .m_axis_rx_metadata_data              (meta_data),
    .m_axis_rx_data_valid                 (data_valid),
    .m_axis_rx_data_ready                 (data_ready),
    .m_axis_rx_data_data                  (data_data),
    .m_axis_rx_data_keep                  (data_keep),
    .m_axis_rx_data_last                  (data_last),
    .ax_minus_b_sign_shifted_result       (result),
    .ax_minus_b_sign_shifted_result_valid (result_valid),
    .drop_cnt                             (drop_cnt),
    .round_cnt                            (round_cnt)
  );

  always #5 clk = ~clk;

  // Count result pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && result_valid[0]) pulse_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One packet: metadata, then nbeats beats. Beat 0 carries b0 in bank 0 and
  // bo in every other bank; later beats carry 0x7FFFFFFF everywhere.
  // Returns #1 after the last beat's handshake edge.
  task automatic send_packet(input logic [15:0] sid, input int nbeats,
                             input logic [31:0] b0, input logic [31:0] bo);
    int wait_cnt;
    @(negedge clk);
    meta_valid = 1'b1;
    meta_data  = sid;
    wait_cnt   = 0;
    while (!meta_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (meta_ready !== 1'b1) begin
      errors++;
      $display("FAIL meta_handshake_timeout: session=%0d ready=%b required=1", sid, meta_ready);
    end
    @(posedge clk);
    #1 meta_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_last  = (b == nbeats - 1);
      data_data  = '0;
      for (int n = 0; n < NB; n++) begin
        if (b == 0) data_data[32*n +: 32] = (n == 0) ? b0 : bo;
        else        data_data[32*n +: 32] = 32'h7FFF_FFFF;
      end
      wait_cnt = 0;
      while (!data_ready && wait_cnt < 50) begin
        @(negedge clk);
        wait_cnt++;
      end
      checks++;
      if (data_ready !== 1'b1) begin
        errors++;
        $display("FAIL data_handshake_timeout: session=%0d beat=%0d ready=%b required=1", sid, b, data_ready);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data_last  = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (meta_ready !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: meta=%b data=%b required 0 0", meta_ready, data_ready);
    end
    checks++;
    if (result_valid !== '0 || result[0] !== 32'sd0 || result[7] !== 32'sd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%h r0=%0d r7=%0d required 0", result_valid, result[0], result[7]);
    end
    checks++;
    if (drop_cnt !== 32'd0 || round_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: drop=%0d round=%0d required 0 0", drop_cnt, round_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (meta_ready !== 1'b0) begin
      errors++;
      $display("FAIL meta_ready_before_edge: got %b required 0", meta_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (meta_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL meta_ready_after_reset: meta=%b data=%b required 1 0", meta_ready, data_ready);
    end
  endtask

  task automatic test_basic_round;
    send_packet(16'd10, 1, 32'd1, 32'hFFFF_FFFF);
    checks++;
    if (result_valid !== '0) begin
      errors++;
      $display("FAIL early_valid: got %h required 0", result_valid);
    end
    send_packet(16'd11, 1, 32'd2, 32'hFFFF_FFFF);
    send_packet(16'd12, 1, 32'd3, 32'hFFFF_FFFF);
    send_packet(16'd13, 1, 32'd4, 32'hFFFF_FFFF);
    checks++;
    if (result_valid !== {NB{1'b1}}) begin
      errors++;
      $display("FAIL basic_valid: got %h required ff", result_valid);
    end
    checks++;
    if (result[0] !== 32'sd10 || result[7] !== -32'sd4) begin
      errors++;
      $display("FAIL basic_sum: r0=%0d r7=%0d required 10 -4", result[0], result[7]);
    end
    checks++;
    if (round_cnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_round_cnt: got %0d required 1", round_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result_valid !== '0 || result[0] !== 32'sd10) begin
      errors++;
      $display("FAIL basic_pulse_hold: valid=%h r0=%0d required 0 10", result_valid, result[0]);
    end
    checks++;
    if (pulse_cnt != 1) begin
      errors++;
      $display("FAIL basic_pulse_count: got %0d required 1", pulse_cnt);
    end
  endtask

  task automatic test_drop_unknown;
    send_packet(16'd99, 1, 32'd100, 32'd0);
    checks++;
    if (drop_cnt !== 32'd1) begin
      errors++;
      $display("FAIL unknown_drop_cnt: got %0d required 1", drop_cnt);
    end
    for (int w = 0; w < NW; w++) send_packet(16'(10 + w), 1, 32'd1, 32'd0);
    checks++;
    if (result[0] !== 32'sd4 || round_cnt !== 32'd2) begin
      errors++;
      $display("FAIL unknown_round: r0=%0d round=%0d required 4 2", result[0], round_cnt);
    end
  endtask

  task automatic test_duplicate;
    send_packet(16'd11, 1, 32'd5, 32'd2);
    send_packet(16'd11, 1, 32'd7, 32'd9);
    checks++;
    if (drop_cnt !== 32'd2) begin
      errors++;
      $display("FAIL dup_drop_cnt: got %0d required 2", drop_cnt);
    end
    send_packet(16'd10, 1, 32'd0, 32'd1);
    send_packet(16'd12, 1, 32'd0, 32'd1);
    send_packet(16'd13, 1, 32'd0, 32'd1);
    checks++;
    if (result[0] !== 32'sd5 || result[1] !== 32'sd5 || round_cnt !== 32'd3) begin
      errors++;
      $display("FAIL dup_round: r0=%0d r1=%0d round=%0d required 5 5 3", result[0], result[1], round_cnt);
    end
  endtask

  task automatic test_multi_beat;
    send_packet(16'd10, 3, 32'hFFFF_FFFD, 32'd0);
    checks++;
    if (meta_ready !== 1'b1 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL multi_back_to_idle: meta=%b data=%b required 1 0", meta_ready, data_ready);
    end
    for (int w = 1; w < NW; w++) send_packet(16'(10 + w), 1, 32'd0, 32'd0);
    checks++;
    if (result[0] !== -32'sd3 || result[1] !== 32'sd0 || round_cnt !== 32'd4) begin
      errors++;
      $display("FAIL multi_round: r0=%0d r1=%0d round=%0d required -3 0 4", result[0], result[1], round_cnt);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_v;
`ifdef SGD_SERVER_RECV_SATURATE_EN
    exp_v = 32'h7FFF_FFFF;
`else
    exp_v = 32'h8000_0000;
`endif
    send_packet(16'd10, 1, 32'h7FFF_FFFF, 32'd0);
    send_packet(16'd11, 1, 32'd1, 32'd0);
    send_packet(16'd12, 1, 32'd0, 32'd0);
    send_packet(16'd13, 1, 32'd0, 32'd0);
    checks++;
    if (result[0] !== exp_v || round_cnt !== 32'd5) begin
      errors++;
      $display("FAIL overflow_sum: r0=%h round=%0d required %h 5", result[0], round_cnt, exp_v);
    end
  endtask

  task automatic test_reset_mid_round;
    send_packet(16'd10, 1, 32'd100, 32'd0);
    send_packet(16'd11, 1, 32'd100, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (round_cnt !== 32'd0 || drop_cnt !== 32'd0 || meta_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: round=%0d drop=%0d meta=%b required 0 0 0", round_cnt, drop_cnt, meta_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b1;
    data_last  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_ready !== 1'b0 || meta_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_data_ready: data=%b meta=%b required 0 1", data_ready, meta_ready);
    end
    data_valid = 1'b0;
    data_last  = 1'b0;
    for (int w = 0; w < NW; w++) send_packet(16'(10 + w), 1, 32'd1, 32'd0);
    checks++;
    if (result[0] !== 32'sd4 || round_cnt !== 32'd1 || result_valid !== {NB{1'b1}}) begin
      errors++;
      $display("FAIL midreset_round: r0=%0d round=%0d valid=%h required 4 1 ff", result[0], round_cnt, result_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pulse_cnt != 6) begin
      errors++;
      $display("FAIL total_pulses: got %0d required 6", pulse_cnt);
    end
  endtask

  initial begin
    for (int w = 0; w < NW; w++) session_id[w] = 16'(10 + w);
    meta_valid = 1'b0;
    meta_data  = '0;
    data_valid = 1'b0;
    data_data  = '0;
    data_keep  = '1;
    data_last  = 1'b0;
    test_reset();
    test_basic_round();
    test_drop_unknown();
    test_duplicate();
    test_multi_beat();
    test_overflow();
    test_reset_mid_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
